issue_unit: RTL and testbench
=============================

Name: issue_unit

Overview:
- Single-entry issue stage between the decoder and the reservation station, the load/store buffer and the ROB.
- Latches one decoded instruction and resolves its source operands from the register file, the ROB and both CDBs.
- Holds the instruction until the ROB and the target station both have room, then issues it with a freshly allocated ROB tag.
- Closes two wakeup holes: a CDB broadcast in the issue cycle, and a back-to-back RAW on the tag being issued.

Parameters:
- VAL_W, 32, operand/immediate/PC width.
- OP_W, 7, op-type width; bits [6:4] give the class.
- LAB_W, 5, ROB label width; 0 = no dependency, tags 1..2^LAB_W-1.
- OP_I_CLASS, 3'b001, class value meaning "operand 2 is the immediate".

Ports:
- clk  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; when low, all state freezes.
- flush  in  1  misprediction flush, qualified by rdy_in.
- dec_valid  in  1  decoder presents an instruction.
- dec_ready  out  1  issue_unit accepts this cycle.
- dec_pc  in  VAL_W  instruction PC.
- dec_type  in  OP_W  op type.
- dec_imm  in  VAL_W  immediate.
- dec_rs1, dec_rs2, dec_rd  in  5  register indices.
- dec_is_ls  in  1  1 = load/store (goes to LSB), 0 = ALU op (goes to RS).
- rf_rs1, rf_rs2  out  5  register-file read indices (driven from dec_rs*).
- rf_lab1, rf_lab2  in  LAB_W  rename label of the register, 0 = committed value.
- rf_val1, rf_val2  in  VAL_W  committed register values.
- rob_q1, rob_q2  out  LAB_W  ROB value-query tags.
- rob_rdy1, rob_rdy2  in  1  queried ROB entry has its result.
- rob_val1, rob_val2  in  VAL_W  queried ROB results.
- rob_full  in  1  ROB cannot allocate.
- rob_new_tag  in  LAB_W  tag the ROB allocates on issue.
- rs_full, lsb_full  in  1  target station full.
- rs_cdb_en, lsb_cdb_en  in  1  CDB broadcast valid.
- rs_cdb_lab, lsb_cdb_lab  in  LAB_W  broadcast tag.
- rs_cdb_val, lsb_cdb_val  in  VAL_W  broadcast value.
- is_rs_en, is_lsb_en, is_rob_en  out  1  issue strobes.
- is_pc, is_imm  out  VAL_W  held PC and immediate.
- is_type  out  OP_W  held op type.
- is_rd  out  5  held destination register.
- is_tag  out  LAB_W  equals rob_new_tag.
- is_lab1, is_lab2  out  LAB_W  unresolved source tags.
- is_rdy1, is_rdy2  out  1  source value valid.
- is_res1, is_res2  out  VAL_W  source values.
- rf_rename_en  out  1  tell the register file that is_rd now maps to is_tag.

Behaviour:
- State: hold_valid plus the held fields, and per-source lab/rdy/val.
  - IDLE = !hold_valid; HOLD = hold_valid.
- Issue condition: fire = hold_valid && !rob_full && (dec_is_ls_h ? !lsb_full : !rs_full).
- Outputs on fire:
  - is_rob_en = fire.
  - is_rs_en = fire && !is_ls_h.
  - is_lsb_en = fire && is_ls_h.
  - rf_rename_en = fire && rd_h != 0.
- Accept condition: dec_ready = rdy_in && !flush && (!hold_valid || fire); accept = dec_valid && dec_ready.
- Transitions:
  - IDLE -> HOLD on accept.
  - HOLD -> IDLE on fire && !accept.
  - HOLD -> HOLD on accept (back-to-back) or stall.
- Latency: an instruction accepted at edge N can issue combinationally in the cycle after edge N; sustained throughput is 1 per cycle.
- Operand capture at accept (per source; x0 forces label 0, value 0). Priority, highest first:
  1. fire && rd_h != 0 && rs == rd_h: lab = rob_new_tag, rdy = 0 (same-cycle rename bypass).
  2. rf_lab == 0: rdy = 1, val = rf_val.
  3. rob_rdy: rdy = 1, val = rob_val.
  4. CDB hit on rf_lab (rs CDB before lsb CDB): rdy = 1, val = CDB value.
  5. Otherwise: rdy = 0, lab = rf_lab.
- Source 2 when dec_type[6:4] == OP_I_CLASS: rdy2 = 1, val2 = dec_imm, lab2 = 0.
- Snoop while HOLD: each cycle, an unready source whose lab matches a valid CDB (rs before lsb) becomes rdy = 1 with the CDB value at the next edge.
- Issue-cycle bypass: is_res*/is_rdy* are the held values, overridden combinationally by a CDB hit in the same cycle. The RS only snoops busy entries, so this bypass is mandatory.
- When is_rdy* = 1, is_lab* is driven as 0.
- Held fields update only on accept. Without an accept they retain their values, including after fire.
- rdy_in low: no state change; all strobes forced to 0.
- Reset or (flush && rdy_in): hold_valid = 0, all held fields 0, all outputs 0 next cycle, dec_ready = 0 during the flush cycle.
- Flush in the same cycle as fire: strobes are suppressed (flush dominates).
- Reset mid-stall: the instruction is dropped; no strobe.
- Tag values only compared when nonzero; a label of 0 never matches a CDB.

Decomposition:
- Shared include: VAL_W, OP_W, LAB_W, op-class codes (OP_I_TYPE etc.), debug START/END_ counters.
- Natural sub-module: operand_resolve, instantiated twice. It holds the capture/snoop/bypass priority logic for one source, with inputs rf/rob/cdb/rename-bypass and outputs lab/rdy/val.

Test Plan:
- ADD x3,x1,x2, both rf_lab=0, rf_val=5/7, no stall -> accepted edge N; next cycle is_rs_en=1, is_res1=5, is_res2=7, rdy both 1, is_tag=rob_new_tag=4.
- ADDI with rf_lab1=6, rob_rdy1=0, then rs_cdb_en with lab 6 val 0x99 in the issue cycle -> is_rdy1=1, is_res1=0x99, is_lab1=0, is_res2=imm.
- Back-to-back ADD x5,x1,x2 then SUB x6,x5,x5 with rob_new_tag=3 at the first fire -> second has is_lab1=is_lab2=3, rdy 0, despite rf_lab=0.
- Load with lsb_full=1 for 3 cycles -> no strobes, dec_ready=0, and lsb CDB wakes src1 during the stall. On release: is_lsb_en=1 exactly once with the woken value.
- Flush while HOLD and fire possible -> no strobes that cycle, hold_valid=0 next cycle. Next dec_valid accepted normally.
- rdy_in=0 during HOLD with a CDB hit -> state and values unchanged; the hit is not captured.

Source files
------------

// File: rtl/issue_unit_pkg.sv
// Shared widths, op-class codes and operand/CDB record types for the issue stage.
package issue_unit_pkg;
  localparam int VAL_W   = 32;
  localparam int OP_W    = 7;
  localparam int LAB_W   = 5;
  localparam int NUM_SRC = 2;

  localparam logic [2:0] OP_I_CLASS = 3'b001;

  typedef struct packed {
    logic             en;
    logic [LAB_W-1:0] lab;
    logic [VAL_W-1:0] val;
  } cdb_t;

  typedef struct packed {
    logic [LAB_W-1:0] lab;
    logic             rdy;
    logic [VAL_W-1:0] val;
  } opnd_t;

  // Label 0 means "no dependency" and must never match a broadcast.
  function automatic logic cdb_hit(cdb_t c, logic [LAB_W-1:0] lab);
    return c.en && (lab != '0) && (c.lab == lab);
  endfunction
endpackage

// File: rtl/issue_unit_if.sv
// Decoder-in / issue-out bundle of the issue stage.
interface issue_unit_if;
  import issue_unit_pkg::*;

  logic             dec_valid, dec_ready;
  logic [VAL_W-1:0] dec_pc, dec_imm;
  logic [OP_W-1:0]  dec_type;
  logic [4:0]       dec_rs1, dec_rs2, dec_rd;
  logic             dec_is_ls;

  logic             is_rs_en, is_lsb_en, is_rob_en;
  logic [VAL_W-1:0] is_pc, is_imm;
  logic [OP_W-1:0]  is_type;
  logic [4:0]       is_rd;
  logic [LAB_W-1:0] is_tag, is_lab1, is_lab2;
  logic             is_rdy1, is_rdy2;
  logic [VAL_W-1:0] is_res1, is_res2;
  logic             rf_rename_en;

  modport master (
    output dec_valid, dec_pc, dec_imm, dec_type, dec_rs1, dec_rs2, dec_rd, dec_is_ls,
    input  dec_ready, is_rs_en, is_lsb_en, is_rob_en, is_pc, is_imm, is_type, is_rd,
           is_tag, is_lab1, is_lab2, is_rdy1, is_rdy2, is_res1, is_res2, rf_rename_en
  );
  modport slave (
    input  dec_valid, dec_pc, dec_imm, dec_type, dec_rs1, dec_rs2, dec_rd, dec_is_ls,
    output dec_ready, is_rs_en, is_lsb_en, is_rob_en, is_pc, is_imm, is_type, is_rd,
           is_tag, is_lab1, is_lab2, is_rdy1, is_rdy2, is_res1, is_res2, rf_rename_en
  );
endinterface

// File: rtl/issue_unit_operand_resolve.sv
// One source operand: capture priority at accept, CDB snoop while held, issue-cycle bypass.
module issue_unit_operand_resolve
  import issue_unit_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             cap,
  input  logic             snoop,
  input  logic             byp_en,
  input  logic [4:0]       rs,
  input  logic             use_imm,
  input  logic [VAL_W-1:0] imm,
  input  logic             ren_hit,
  input  logic [LAB_W-1:0] new_tag,
  input  logic [LAB_W-1:0] rf_lab,
  input  logic [VAL_W-1:0] rf_val,
  input  logic             rob_rdy,
  input  logic [VAL_W-1:0] rob_val,
  input  cdb_t             cdb_rs,
  input  cdb_t             cdb_lsb,
  output opnd_t            opnd
);
  opnd_t held, cap_d, wake;

  always_comb begin
    cap_d = '0;
    if (use_imm) begin
      cap_d.rdy = 1'b1;
      cap_d.val = imm;
    end else if (rs == '0) begin
      cap_d.rdy = 1'b1;
    end else if (ren_hit) begin
      // producer is issuing this very cycle; the RF label is stale
      cap_d.lab = new_tag;
    end else if (rf_lab == '0) begin
      cap_d.rdy = 1'b1;
      cap_d.val = rf_val;
    end else if (rob_rdy) begin
      cap_d.rdy = 1'b1;
      cap_d.val = rob_val;
    end else if (cdb_hit(cdb_rs, rf_lab)) begin
      cap_d.rdy = 1'b1;
      cap_d.val = cdb_rs.val;
    end else if (cdb_hit(cdb_lsb, rf_lab)) begin
      cap_d.rdy = 1'b1;
      cap_d.val = cdb_lsb.val;
    end else begin
      cap_d.lab = rf_lab;
    end
  end

  always_comb begin
    wake = held;
    if (!held.rdy) begin
      if (cdb_hit(cdb_rs, held.lab))       wake = '{lab: '0, rdy: 1'b1, val: cdb_rs.val};
      else if (cdb_hit(cdb_lsb, held.lab)) wake = '{lab: '0, rdy: 1'b1, val: cdb_lsb.val};
    end
  end

  always_ff @(posedge clk) begin
    if (clr)        held <= '0;
    else if (cap)   held <= cap_d;
    else if (snoop) held <= wake;
  end

  assign opnd = byp_en ? wake : held;
endmodule

// File: rtl/issue_unit.sv
// Single-entry issue stage: holds one decoded instruction until ROB and target station have room.
module issue_unit
  import issue_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  issue_unit_if.slave      bus,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  input  logic [LAB_W-1:0] rf_lab1,
  input  logic [LAB_W-1:0] rf_lab2,
  input  logic [VAL_W-1:0] rf_val1,
  input  logic [VAL_W-1:0] rf_val2,
  output logic [LAB_W-1:0] rob_q1,
  output logic [LAB_W-1:0] rob_q2,
  input  logic             rob_rdy1,
  input  logic             rob_rdy2,
  input  logic [VAL_W-1:0] rob_val1,
  input  logic [VAL_W-1:0] rob_val2,
  input  logic             rob_full,
  input  logic [LAB_W-1:0] rob_new_tag,
  input  logic             rs_full,
  input  logic             lsb_full,
  input  logic             rs_cdb_en,
  input  logic [LAB_W-1:0] rs_cdb_lab,
  input  logic [VAL_W-1:0] rs_cdb_val,
  input  logic             lsb_cdb_en,
  input  logic [LAB_W-1:0] lsb_cdb_lab,
  input  logic [VAL_W-1:0] lsb_cdb_val
);
  logic             hold_valid, is_ls_h;
  logic [VAL_W-1:0] pc_h, imm_h;
  logic [OP_W-1:0]  type_h;
  logic [4:0]       rd_h;
  logic             go, clr, fire, accept, snoop, imm_op;

  logic  [NUM_SRC-1:0][4:0]       src_rs;
  logic  [NUM_SRC-1:0][LAB_W-1:0] src_lab;
  logic  [NUM_SRC-1:0][VAL_W-1:0] src_rf_val, src_rob_val;
  logic  [NUM_SRC-1:0]            src_rob_rdy;
  opnd_t [NUM_SRC-1:0]            src_op;
  cdb_t                           rs_cdb, lsb_cdb;

  // Flush and reset both dominate any fire in the same cycle.
  assign go     = rdy_in && !flush && !rst_in;
  assign clr    = rst_in || (rdy_in && flush);
  assign fire   = hold_valid && go && !rob_full && (is_ls_h ? !lsb_full : !rs_full);
  assign snoop  = hold_valid && rdy_in && !fire;
  assign accept = bus.dec_valid && bus.dec_ready;
  assign imm_op = bus.dec_type[OP_W-1 -: 3] == OP_I_CLASS;

  assign bus.dec_ready    = go && (!hold_valid || fire);
  assign bus.is_rob_en    = fire;
  assign bus.is_rs_en     = fire && !is_ls_h;
  assign bus.is_lsb_en    = fire && is_ls_h;
  assign bus.rf_rename_en = fire && (rd_h != '0);
  assign bus.is_tag       = hold_valid ? rob_new_tag : '0;
  assign bus.is_pc        = pc_h;
  assign bus.is_imm       = imm_h;
  assign bus.is_type      = type_h;
  assign bus.is_rd        = rd_h;

  assign rf_rs1 = bus.dec_rs1;
  assign rf_rs2 = bus.dec_rs2;
  assign rob_q1 = rf_lab1;
  assign rob_q2 = rf_lab2;

  assign src_rs      = {bus.dec_rs2, bus.dec_rs1};
  assign src_lab     = {rf_lab2, rf_lab1};
  assign src_rf_val  = {rf_val2, rf_val1};
  assign src_rob_rdy = {rob_rdy2, rob_rdy1};
  assign src_rob_val = {rob_val2, rob_val1};
  assign rs_cdb      = '{en: rs_cdb_en, lab: rs_cdb_lab, val: rs_cdb_val};
  assign lsb_cdb     = '{en: lsb_cdb_en, lab: lsb_cdb_lab, val: lsb_cdb_val};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    issue_unit_operand_resolve u_opr (
      .clk     (clk),
      .clr     (clr),
      .cap     (accept),
      .snoop   (snoop),
      .byp_en  (rdy_in),
      .rs      (src_rs[i]),
      .use_imm ((i == 1) && imm_op),
      .imm     (bus.dec_imm),
      .ren_hit (fire && (rd_h != '0) && (src_rs[i] == rd_h)),
      .new_tag (rob_new_tag),
      .rf_lab  (src_lab[i]),
      .rf_val  (src_rf_val[i]),
      .rob_rdy (src_rob_rdy[i]),
      .rob_val (src_rob_val[i]),
      .cdb_rs  (rs_cdb),
      .cdb_lsb (lsb_cdb),
      .opnd    (src_op[i])
    );
  end

  assign bus.is_lab1 = src_op[0].lab;
  assign bus.is_rdy1 = src_op[0].rdy;
  assign bus.is_res1 = src_op[0].val;
  assign bus.is_lab2 = src_op[1].lab;
  assign bus.is_rdy2 = src_op[1].rdy;
  assign bus.is_res2 = src_op[1].val;

  always_ff @(posedge clk) begin
    if (clr) begin
      hold_valid <= 1'b0;
      is_ls_h    <= 1'b0;
      pc_h       <= '0;
      imm_h      <= '0;
      type_h     <= '0;
      rd_h       <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      is_ls_h    <= bus.dec_is_ls;
      pc_h       <= bus.dec_pc;
      imm_h      <= bus.dec_imm;
      type_h     <= bus.dec_type;
      rd_h       <= bus.dec_rd;
    end else if (fire) begin
      hold_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit with a per-cycle reference model and literal spot checks.
module tb_issue_unit;
  import issue_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic [4:0]  rf_rs1, rf_rs2, rf_lab1, rf_lab2, rob_q1, rob_q2, rob_new_tag;
  logic [31:0] rf_val1, rf_val2, rob_val1, rob_val2;
  logic        rob_rdy1, rob_rdy2, rob_full, rs_full, lsb_full;
  logic        rs_cdb_en, lsb_cdb_en;
  logic [4:0]  rs_cdb_lab, lsb_cdb_lab;
  logic [31:0] rs_cdb_val, lsb_cdb_val;

  issue_unit_if bus();

  issue_unit dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .bus(bus),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_lab1(rf_lab1), .rf_lab2(rf_lab2),
    .rf_val1(rf_val1), .rf_val2(rf_val2), .rob_q1(rob_q1), .rob_q2(rob_q2),
    .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2), .rob_val1(rob_val1), .rob_val2(rob_val2),
    .rob_full(rob_full), .rob_new_tag(rob_new_tag), .rs_full(rs_full), .lsb_full(lsb_full),
    .rs_cdb_en(rs_cdb_en), .rs_cdb_lab(rs_cdb_lab), .rs_cdb_val(rs_cdb_val),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_lab(lsb_cdb_lab), .lsb_cdb_val(lsb_cdb_val)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the held instruction as a record, sources as ready-value or waited-on tag.
  typedef struct { bit rdy; logic [31:0] val; logic [4:0] tag; } src_t;
  bit          m_valid, m_ls;
  logic [31:0] m_pc, m_imm;
  logic [6:0]  m_type;
  logic [4:0]  m_rd;
  src_t        m_src[2];

  function automatic logic [32:0] cdb_look(input logic [4:0] tag);
    if (tag == 0) return '0;
    if (rs_cdb_en && rs_cdb_lab == tag) return {1'b1, rs_cdb_val};
    if (lsb_cdb_en && lsb_cdb_lab == tag) return {1'b1, lsb_cdb_val};
    return '0;
  endfunction

  function automatic bit m_fire();
    return m_valid && rdy_in && !flush && !rst_in && !rob_full && (m_ls ? !lsb_full : !rs_full);
  endfunction

  function automatic bit m_ready();
    return rdy_in && !flush && !rst_in && (!m_valid || m_fire());
  endfunction

  function automatic src_t shown(input int i);
    src_t s;
    logic [32:0] c;
    s = m_src[i];
    if (!s.rdy && rdy_in) begin
      c = cdb_look(s.tag);
      if (c[32]) begin s.rdy = 1; s.val = c[31:0]; s.tag = 0; end
    end
    return s;
  endfunction

  function automatic src_t capture(input int i, input bit f);
    src_t s;
    logic [4:0] rs, lab;
    logic [32:0] c;
    rs  = (i == 0) ? bus.dec_rs1 : bus.dec_rs2;
    lab = (i == 0) ? rf_lab1 : rf_lab2;
    c   = cdb_look(lab);
    s   = '{rdy: 0, val: 0, tag: 0};
    if (i == 1 && bus.dec_type[6:4] == 3'b001) begin s.rdy = 1; s.val = bus.dec_imm; end
    else if (rs == 0) s.rdy = 1;
    else if (f && m_rd != 0 && rs == m_rd) s.tag = rob_new_tag;
    else if (lab == 0) begin s.rdy = 1; s.val = (i == 0) ? rf_val1 : rf_val2; end
    else if ((i == 0) ? rob_rdy1 : rob_rdy2) begin s.rdy = 1; s.val = (i == 0) ? rob_val1 : rob_val2; end
    else if (c[32]) begin s.rdy = 1; s.val = c[31:0]; end
    else s.tag = lab;
    return s;
  endfunction

  always @(posedge clk) begin : mdl
    bit f, acc;
    src_t n0, n1;
    f   = m_fire();
    acc = bus.dec_valid && m_ready();
    if (rst_in || (rdy_in && flush)) begin
      m_valid = 0; m_ls = 0; m_pc = 0; m_imm = 0; m_type = 0; m_rd = 0;
      m_src[0] = '{rdy: 0, val: 0, tag: 0};
      m_src[1] = '{rdy: 0, val: 0, tag: 0};
    end else if (rdy_in) begin
      if (acc) begin
        n0 = capture(0, f);
        n1 = capture(1, f);
        m_src[0] = n0; m_src[1] = n1;
        m_valid = 1; m_ls = bus.dec_is_ls; m_pc = bus.dec_pc; m_imm = bus.dec_imm;
        m_type = bus.dec_type; m_rd = bus.dec_rd;
      end else if (f) begin
        m_valid = 0;
      end else if (m_valid) begin
        n0 = shown(0);
        n1 = shown(1);
        m_src[0] = n0; m_src[1] = n1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit f;
    src_t s0, s1;
    if (started) begin
      f  = m_fire();
      s0 = shown(0);
      s1 = shown(1);
      chk("m_rob_en", bus.is_rob_en, f);
      chk("m_rs_en", bus.is_rs_en, f && !m_ls);
      chk("m_lsb_en", bus.is_lsb_en, f && m_ls);
      chk("m_rename", bus.rf_rename_en, f && m_rd != 0);
      chk("m_dec_ready", bus.dec_ready, m_ready());
      chk("m_pc", bus.is_pc, m_pc);
      chk("m_imm", bus.is_imm, m_imm);
      chk("m_type", bus.is_type, m_type);
      chk("m_rd", bus.is_rd, m_rd);
      if (f) chk("m_tag", bus.is_tag, rob_new_tag);
      chk("m_rdy1", bus.is_rdy1, s0.rdy);
      chk("m_lab1", bus.is_lab1, s0.tag);
      if (s0.rdy) chk("m_res1", bus.is_res1, s0.val);
      chk("m_rdy2", bus.is_rdy2, s1.rdy);
      chk("m_lab2", bus.is_lab2, s1.tag);
      if (s1.rdy) chk("m_res2", bus.is_res2, s1.val);
      chk("m_rf_rs1", rf_rs1, bus.dec_rs1);
      chk("m_rf_rs2", rf_rs2, bus.dec_rs2);
      chk("m_rob_q1", rob_q1, rf_lab1);
      chk("m_rob_q2", rob_q2, rf_lab2);
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic neg();  @(negedge clk); endtask

  task automatic idle_in();
    rdy_in = 1; flush = 0;
    bus.dec_valid = 0; bus.dec_pc = 0; bus.dec_type = 0; bus.dec_imm = 0;
    bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0; bus.dec_is_ls = 0;
    rf_lab1 = 0; rf_lab2 = 0; rf_val1 = 0; rf_val2 = 0;
    rob_rdy1 = 0; rob_rdy2 = 0; rob_val1 = 0; rob_val2 = 0;
    rob_full = 0; rob_new_tag = 0; rs_full = 0; lsb_full = 0;
    rs_cdb_en = 0; rs_cdb_lab = 0; rs_cdb_val = 0;
    lsb_cdb_en = 0; lsb_cdb_lab = 0; lsb_cdb_val = 0;
  endtask

  task automatic dec(input logic [31:0] pc, input logic [6:0] ty, input logic [31:0] imm,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input bit ls);
    bus.dec_valid = 1; bus.dec_pc = pc; bus.dec_type = ty; bus.dec_imm = imm;
    bus.dec_rs1 = r1; bus.dec_rs2 = r2; bus.dec_rd = rd; bus.dec_is_ls = ls;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    idle_in(); rst_in = 1;
    step(); started = 1;
    neg(); chk("rst_dec_ready", bus.dec_ready, 0);
    step(); rst_in = 0;
    neg();
    chk("rst_rs_en", bus.is_rs_en, 0); chk("rst_rdy1", bus.is_rdy1, 0);
    chk("rst_pc", bus.is_pc, 0); chk("idle_ready", bus.dec_ready, 1);

    // ADD x3,x1,x2
    dec(32'h100, 7'h00, 0, 1, 2, 3, 0); rf_val1 = 5; rf_val2 = 7; rob_new_tag = 4;
    step(); bus.dec_valid = 0;
    neg();
    chk("add_rs_en", bus.is_rs_en, 1); chk("add_res1", bus.is_res1, 5);
    chk("add_res2", bus.is_res2, 7); chk("add_rdy1", bus.is_rdy1, 1);
    chk("add_rdy2", bus.is_rdy2, 1); chk("add_tag", bus.is_tag, 4);
    chk("add_rename", bus.rf_rename_en, 1);
    step(); neg(); chk("add_once", bus.is_rs_en, 0);

    // ADDI x7,x1,0x55 with src1 woken by rs CDB in the issue cycle
    idle_in(); dec(32'h104, 7'b0010000, 32'h55, 1, 0, 7, 0); rf_lab1 = 6;
    step(); bus.dec_valid = 0; rs_cdb_en = 1; rs_cdb_lab = 6; rs_cdb_val = 32'h99; rob_new_tag = 5;
    neg();
    chk("addi_rdy1", bus.is_rdy1, 1); chk("addi_res1", bus.is_res1, 32'h99);
    chk("addi_lab1", bus.is_lab1, 0); chk("addi_res2", bus.is_res2, 32'h55);
    chk("addi_rs_en", bus.is_rs_en, 1);
    step();

    // back-to-back RAW: ADD x5,x1,x2 ; SUB x6,x5,x5
    idle_in(); dec(32'h108, 7'h00, 0, 1, 2, 5, 0); rf_val1 = 1; rf_val2 = 2;
    step();
    dec(32'h10c, 7'h08, 0, 5, 5, 6, 0); rf_val1 = 32'h11; rf_val2 = 32'h11; rob_new_tag = 3;
    neg();
    chk("b2b_tag", bus.is_tag, 3); chk("b2b_fire", bus.is_rs_en, 1); chk("b2b_ready", bus.dec_ready, 1);
    step(); bus.dec_valid = 0; rob_new_tag = 8;
    neg();
    chk("b2b_lab1", bus.is_lab1, 3); chk("b2b_lab2", bus.is_lab2, 3);
    chk("b2b_rdy1", bus.is_rdy1, 0); chk("b2b_rdy2", bus.is_rdy2, 0);
    chk("b2b_rd", bus.is_rd, 6); chk("b2b_fire2", bus.is_rs_en, 1);
    step();

    // load stalled by lsb_full, src1 woken by lsb CDB during the stall
    idle_in(); dec(32'h110, 7'b0100000, 32'h4, 4, 0, 9, 1); rf_lab1 = 9; lsb_full = 1;
    step(); bus.dec_valid = 0; rf_lab1 = 0;
    neg();
    chk("ld_stall_en", bus.is_lsb_en, 0); chk("ld_stall_ready", bus.dec_ready, 0);
    chk("ld_lab1", bus.is_lab1, 9);
    step(); lsb_cdb_en = 1; lsb_cdb_lab = 9; lsb_cdb_val = 32'h1234;
    neg(); chk("ld_stall_en2", bus.is_lsb_en, 0); chk("ld_byp_rdy1", bus.is_rdy1, 1);
    step(); lsb_cdb_en = 0;
    neg();
    chk("ld_woke_rdy1", bus.is_rdy1, 1); chk("ld_woke_res1", bus.is_res1, 32'h1234);
    chk("ld_stall_en3", bus.is_lsb_en, 0);
    step(); lsb_full = 0;
    neg();
    chk("ld_issue", bus.is_lsb_en, 1); chk("ld_rs_en", bus.is_rs_en, 0);
    chk("ld_res1", bus.is_res1, 32'h1234); chk("ld_res2_x0", bus.is_res2, 0);
    step(); neg(); chk("ld_once", bus.is_lsb_en, 0);

    // flush while fire is possible; decoder keeps presenting
    idle_in(); dec(32'h120, 7'h00, 0, 1, 2, 2, 0); rf_val1 = 3; rf_val2 = 4;
    step(); dec(32'h130, 7'h00, 0, 1, 2, 2, 0); flush = 1;
    neg();
    chk("fl_rs_en", bus.is_rs_en, 0); chk("fl_rob_en", bus.is_rob_en, 0);
    chk("fl_ready", bus.dec_ready, 0); chk("fl_rename", bus.rf_rename_en, 0);
    step(); flush = 0; bus.dec_valid = 0;
    neg();
    chk("fl_pc", bus.is_pc, 0); chk("fl_rdy1", bus.is_rdy1, 0);
    chk("fl_idle_en", bus.is_rs_en, 0); chk("fl_ready2", bus.dec_ready, 1);
    dec(32'h124, 7'h00, 0, 1, 2, 3, 0); rf_val1 = 8; rf_val2 = 9;
    step(); bus.dec_valid = 0;
    neg(); chk("fl_next_en", bus.is_rs_en, 1); chk("fl_next_res1", bus.is_res1, 8);
    chk("fl_next_pc", bus.is_pc, 32'h124);
    step();

    // rdy_in low freezes state and hides a CDB hit
    idle_in(); dec(32'h140, 7'h00, 0, 1, 2, 4, 0);
    rf_lab1 = 10; rf_lab2 = 11; rob_rdy2 = 1; rob_val2 = 32'habc; rs_full = 1;
    step(); bus.dec_valid = 0; rf_lab1 = 0; rf_lab2 = 0; rob_rdy2 = 0;
    neg(); chk("rob_res2", bus.is_res2, 32'habc); chk("rob_lab1", bus.is_lab1, 10);
    step(); rdy_in = 0; rs_cdb_en = 1; rs_cdb_lab = 10; rs_cdb_val = 32'h77; rs_full = 0;
    neg(); chk("frz_rdy1", bus.is_rdy1, 0); chk("frz_en", bus.is_rs_en, 0);
    chk("frz_ready", bus.dec_ready, 0);
    step(); rdy_in = 1; rs_cdb_en = 0;
    neg(); chk("frz_rdy1b", bus.is_rdy1, 0); chk("frz_lab1", bus.is_lab1, 10);
    chk("frz_issue", bus.is_rs_en, 1);
    step();

    // reset in the middle of a stall drops the instruction
    idle_in(); dec(32'h150, 7'h00, 0, 1, 2, 5, 0); rs_full = 1;
    step(); bus.dec_valid = 0;
    neg(); chk("rs_stall_en", bus.is_rs_en, 0);
    step(); rst_in = 1; rs_full = 0;
    neg(); chk("rstm_en", bus.is_rs_en, 0); chk("rstm_rename", bus.rf_rename_en, 0);
    step(); rst_in = 0;
    neg(); chk("rstm_after_en", bus.is_rs_en, 0); chk("rstm_pc", bus.is_pc, 0);
    chk("rstm_ready", bus.dec_ready, 1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
